// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive control path: FSM states,
// legal oversampling ratios and small combinational helpers.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESC_W_DEF    = 6;

    localparam int unsigned PRESC_8  = 32'd8;
    localparam int unsigned PRESC_16 = 32'd16;
    localparam int unsigned PRESC_32 = 32'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // 2-of-3 majority of the three oversamples
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic presc_is_legal(input int unsigned p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_rx_data_sampling.sv
// Oversampler: captures RX_IN around mid-bit and registers the
// majority-voted bit two edges after the centre sample.
module rx_data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [PRESC_W-1:0] edge_cnt_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               rx_in_i,
    output logic               sampled_bit_o
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

    logic [PRESC_W-1:0] half_s;
    logic [2:0]         samp_q, samp_d;
    logic               sampled_q, sampled_d;

    assign half_s = prescale_i >> 1;

    // Sample capture and vote; everything holds outside the four sample edges
    always_comb begin
        samp_d    = samp_q;
        sampled_d = sampled_q;
        if (edge_cnt_i == (half_s - ONE)) begin
            samp_d[0] = rx_in_i;
        end else if (edge_cnt_i == half_s) begin
            samp_d[1] = rx_in_i;
        end else if (edge_cnt_i == (half_s + ONE)) begin
            samp_d[2] = rx_in_i;
        end else if (edge_cnt_i == (half_s + TWO)) begin
            sampled_d = maj3(samp_q);
        end else begin
            sampled_d = sampled_q;
        end
    end

    // Sample and vote registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q    <= 3'b000;
            sampled_q <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            sampled_q <= sampled_d;
        end
    end

    assign sampled_bit_o = sampled_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start detection, bit timing, LSB-first
// deserialization, parity-checker strobe and stop-bit validation.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  Parity_Error,
    output logic                  sampled_bit,
    output logic                  par_chk_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  framing_error
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESC_W-1:0] ONE      = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO      = PRESC_W'(2);
    localparam logic [PRESC_W-1:0] P_SAFE   = PRESC_W'(PRESC_8);
    localparam logic [BW-1:0]      LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  framing_error_q, framing_error_d;
    logic                  par_chk_en_q, par_chk_en_d;

    logic                  sampled_bit_s;
    logic                  last_edge_s;
    logic                  pre_last_edge_s;

    rx_data_sampling #(
        .PRESC_W (PRESC_W)
    ) u_sampling (
        .CLK           (CLK),
        .RST           (RST),
        .edge_cnt_i    (edge_cnt_q),
        .prescale_i    (presc_q),
        .rx_in_i       (RX_IN),
        .sampled_bit_o (sampled_bit_s)
    );

    assign last_edge_s     = (edge_cnt_q == (presc_q - ONE));
    assign pre_last_edge_s = (edge_cnt_q == (presc_q - TWO));

    // Next-state, counters, deserializer and output strobes
    always_comb begin
        state_d         = state_q;
        edge_cnt_d      = edge_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        presc_d         = presc_q;
        par_en_d        = par_en_q;
        p_data_d        = p_data_q;
        data_valid_d    = 1'b0;
        framing_error_d = framing_error_q;
        par_chk_en_d    = 1'b0;

        if (state_q == IDLE) begin
            edge_cnt_d = '0;
        end else if (last_edge_s) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    // An out-of-range ratio falls back to 8 so the bit timer stays sane
                    presc_d         = presc_is_legal(32'(Prescale)) ? Prescale : P_SAFE;
                    par_en_d        = PAR_EN;
                    framing_error_d = 1'b0;
                    edge_cnt_d      = ONE;
                    state_d         = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (last_edge_s) begin
                    if (!sampled_bit_s) begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (last_edge_s) begin
                    p_data_d = {sampled_bit_s, p_data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                // Registered one edge early so the strobe coincides with edge P-1
                if (pre_last_edge_s) begin
                    par_chk_en_d = 1'b1;
                end else begin
                    par_chk_en_d = 1'b0;
                end
                if (last_edge_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (last_edge_s) begin
                    framing_error_d = ~sampled_bit_s;
                    data_valid_d    = sampled_bit_s & ~(par_en_q & Parity_Error);
                    state_d         = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            edge_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            presc_q         <= P_SAFE;
            par_en_q        <= 1'b0;
            p_data_q        <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            par_chk_en_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            edge_cnt_q      <= edge_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            presc_q         <= presc_d;
            par_en_q        <= par_en_d;
            p_data_q        <= p_data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            par_chk_en_q    <= par_chk_en_d;
        end
    end

    assign sampled_bit   = sampled_bit_s;
    assign par_chk_en    = par_chk_en_q;
    assign P_DATA        = p_data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;

endmodule
